// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Pure declarations: no latency, no flow control.
package mult_pkg;
    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;
    localparam int PROD_WIDTH = 65;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

    // Pair is {current multiplier bit, previously shifted-out bit}.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/booth_multiplier_if.sv
// Operand/result bundle between the multdiv issue logic and the Booth multiplier.
// Single start pulse in; single ready strobe out; busy for the duration of RUN.
interface booth_multiplier_if;
    logic                           ctrl_mult;
    logic [mult_pkg::MULT_WIDTH-1:0] data_a;
    logic [mult_pkg::MULT_WIDTH-1:0] data_b;
    logic [mult_pkg::MULT_WIDTH-1:0] data_result;
    logic                           data_resultRDY;
    logic                           data_exception;
    logic                           busy;

    modport master (
        output ctrl_mult, data_a, data_b,
        input  data_result, data_resultRDY, data_exception, busy
    );

    modport slave (
        input  ctrl_mult, data_a, data_b,
        output data_result, data_resultRDY, data_exception, busy
    );
endinterface

// File: rtl/register65.sv
// 65-bit product register {hi, lo, q_m1} with load enable; one-cycle latency.
// Active-high asynchronous clear; holds its value whenever input_enable is low.
module register65
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_enable,
    input  logic [PROD_WIDTH-1:0] data_in,
    output logic [PROD_WIDTH-1:0] data_out
);
    logic [PROD_WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (input_enable) data_d = data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign data_out = data_q;
endmodule

// File: rtl/booth_multiplier.sv
// Radix-2 Booth 32x32 signed multiplier: 33 cycles start-to-strobe, starts during RUN are dropped.
// MULT_OVERFLOW_EN adds a registered signed-32-bit overflow flag; otherwise data_exception is 0.
module booth_multiplier
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    booth_multiplier_if.slave mif
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            state_q, state_d;
    logic [MULT_WIDTH-1:0] mcand_q, mcand_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [MULT_WIDTH-1:0] result_q, result_d;

    logic [PROD_WIDTH-1:0] p_q, p_d, p_shift;
    logic                  p_en;
    logic                  start;
    logic [MULT_WIDTH:0]   sum;
    booth_op_e             op;

    always_comb begin
        start = mif.ctrl_mult && (state_q == ST_IDLE || state_q == ST_DONE);
        op    = booth_decode(p_q[1:0]);
        // 33-bit sum so the shift-in bit is correct even for mcand = 0x80000000.
        case (op)
            ADD:     sum = {p_q[64], p_q[64:33]} + {mcand_q[31], mcand_q};
            SUB:     sum = {p_q[64], p_q[64:33]} - {mcand_q[31], mcand_q};
            default: sum = {p_q[64], p_q[64:33]};
        endcase
        p_shift = {sum, p_q[32:1]};
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        p_d      = p_shift;
        p_en     = 1'b0;
        case (state_q)
            ST_RUN: begin
                p_en  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MULT_ITERS - 1)) begin
                    state_d  = ST_DONE;
                    result_d = p_shift[32:1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    mcand_d = mif.data_a;
                    cnt_d   = '0;
                    p_d     = {32'b0, mif.data_b, 1'b0};
                    p_en    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    register65 u_preg (
        .clk          (clk),
        .reset        (~reset),
        .input_enable (p_en),
        .data_in      (p_d),
        .data_out     (p_q)
    );

`ifdef MULT_OVERFLOW_EN
    logic exc_q, exc_d;

    // Product fits in 32 signed bits only if P[64:32] is pure sign extension.
    always_comb begin
        exc_d = exc_q;
        if (state_q == ST_RUN && cnt_q == 5'(MULT_ITERS - 1))
            exc_d = ~((&p_shift[64:32]) | ~(|p_shift[64:32]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) exc_q <= 1'b0;
        else        exc_q <= exc_d;
    end

    assign mif.data_exception = exc_q;
`else
    assign mif.data_exception = 1'b0;
`endif

    assign mif.data_result    = result_q;
    assign mif.data_resultRDY = (state_q == ST_DONE);
    assign mif.busy           = (state_q == ST_RUN);
endmodule

// File: tb/tb_booth_multiplier.sv
// Randomised and directed checks of booth_multiplier against a plain-arithmetic product model.
module tb_booth_multiplier;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    booth_multiplier_if mif ();

    booth_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_OVERFLOW_EN
        logic [63:0] p;
        logic [31:0] lo;
        p  = ref_prod(a, b);
        lo = p[31:0];
        return (64'(longint'($signed(lo))) != p);
`else
        return (a != a);
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'(signed'($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        mif.ctrl_mult = 1'b1;
        mif.data_a    = a;
        mif.data_b    = b;
    endtask

    // Called with a start already driven; returns at #1 after the strobe edge (DONE cycle).
    task automatic collect(input string tag, input logic [31:0] a, input logic [31:0] b, input int ign);
        int lat;
        int busy_bad;
        bit got;
        logic [63:0] p;
        @(posedge clk);
        #1;
        mif.ctrl_mult = 1'b0;
        mif.data_a    = $urandom;
        mif.data_b    = $urandom;
        lat      = 1;
        busy_bad = 0;
        got      = 1'b0;
        while (!got && lat < 40) begin
            mif.ctrl_mult = (lat == ign);
            if (lat == ign) begin
                mif.data_a = 32'd1;
                mif.data_b = 32'd1;
            end
            @(posedge clk);
            #1;
            lat++;
            got = mif.data_resultRDY;
            if (!got && mif.busy !== 1'b1) busy_bad++;
        end
        mif.ctrl_mult = 1'b0;
        p = ref_prod(a, b);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        chk({tag, "_busy_done"}, 64'(mif.busy), 64'd0);
        chk({tag, "_result"}, 64'(mif.data_result), {32'b0, p[31:0]});
        chk({tag, "_exc"}, 64'(mif.data_exception), 64'(ref_exc(a, b)));
    endtask

    task automatic hold_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ref_prod(a, b);
        @(posedge clk);
        #1;
        chk({tag, "_rdy_drop"}, 64'(mif.data_resultRDY), 64'd0);
        chk({tag, "_hold"}, 64'(mif.data_result), {32'b0, p[31:0]});
    endtask

    logic [31:0] dir_a [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0064};
    logic [31:0] dir_b [4] = '{32'h0000_0006, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FF38};

    initial begin
        logic [31:0] ra, rb;
        int strobes;
        mif.ctrl_mult = 1'b0;
        mif.data_a    = '0;
        mif.data_b    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 64'(mif.data_result), 64'd0);
        chk("rst_rdy",    64'(mif.data_resultRDY), 64'd0);
        chk("rst_exc",    64'(mif.data_exception), 64'd0);
        chk("rst_busy",   64'(mif.busy), 64'd0);

        // First edge after release already samples the start.
        @(negedge clk);
        reset = 1'b1;
        drive(32'd3, 32'd5);
        collect("m3x5", 32'd3, 32'd5, 0);
        hold_check("m3x5", 32'd3, 32'd5);

        for (int i = 0; i < 4; i++) begin
            drive(dir_a[i], dir_b[i]);
            collect($sformatf("dir%0d", i), dir_a[i], dir_b[i], 0);
            hold_check($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
        end

        drive(32'd10, 32'd10);
        collect("ignored_start", 32'd10, 32'd10, 15);

        // Back-to-back start in the DONE cycle.
        drive(32'hFFFF_0000, 32'h0001_0000);
        collect("b2b", 32'hFFFF_0000, 32'h0001_0000, 0);
        hold_check("b2b", 32'hFFFF_0000, 32'h0001_0000);

        // Reset mid-run: everything clears, no strobe afterwards.
        drive(32'd5, 32'd7);
        @(posedge clk);
        #1;
        mif.ctrl_mult = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy",   64'(mif.busy), 64'd0);
        chk("midrst_rdy",    64'(mif.data_resultRDY), 64'd0);
        chk("midrst_result", 64'(mif.data_result), 64'd0);
        chk("midrst_exc",    64'(mif.data_exception), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        strobes = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mif.data_resultRDY === 1'b1) strobes++;
        end
        chk("midrst_no_strobe", 64'(strobes), 64'd0);

        drive(32'd9, 32'd9);
        collect("pre_restart", 32'd9, 32'd9, 0);
        drive(32'd4, 32'd4);
        collect("restart4x4", 32'd4, 32'd4, 0);
        hold_check("restart4x4", 32'd4, 32'd4);

        for (int i = 0; i < 30; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            drive(ra, rb);
            collect($sformatf("rnd%0d", i), ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
        end
        hold_check("rnd_last", ra, rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
